// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered pixel-fetch addressing.
// Sync and data-enable are delayed to line up with pixel data returned PIX_LAT clocks later.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_LAT  = 1
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [1:0]  mode,
  input  logic [11:0] pixel_data,
  output logic [11:0] row_addr,
  output logic [11:0] col_addr,
  output logic        fetch_en,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start,
  output logic        line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] H_START    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END      = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] V_START    = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_END      = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [12:0] BAR_DIV    = 13'(H_ACTIVE);

  localparam logic HS_ON  = 1'(HS_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(VS_POL);
  localparam logic VS_OFF = ~VS_ON;

  typedef enum logic [1:0] {
    MODE_RGB   = 2'b00,
    MODE_MONO  = 2'b01,
    MODE_BARS  = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;

  // Control bundle that travels alongside the pixel fetch.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       ls;
    logic [2:0] bar;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: HS_OFF, vs: VS_OFF, de: 1'b0, fs: 1'b0, ls: 1'b0, bar: 3'd0};

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic [11:0] r_bar_acc;
  logic [2:0]  r_bar_idx;
  logic [11:0] r_row_addr;
  logic [11:0] r_col_addr;
  mode_e       r_mode_q;
  ctl_t        r_dly [0:PIX_LAT];
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_fs;
  logic        r_ls;

  logic        w_h_active;
  logic        w_v_active;
  logic        w_fetch;
  logic        w_line_first;
  logic [12:0] w_bar_sum;
  ctl_t        w_ctl0;
  ctl_t        w_tail;
  logic [11:0] w_rgb;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  assign w_h_active   = (r_h_cnt >= H_START) && (r_h_cnt < H_END);
  assign w_v_active   = (r_v_cnt >= V_START) && (r_v_cnt < V_END);
  assign w_fetch      = w_h_active && w_v_active;
  assign w_line_first = w_fetch && (r_h_cnt == H_START);

  // Bar index = col*8/H_ACTIVE tracked as a running remainder, so no divider is needed.
  assign w_bar_sum = {1'b0, r_bar_acc} + 13'd8;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_bar_acc <= '0;
      r_bar_idx <= '0;
    end else if (!w_h_active) begin
      r_bar_acc <= '0;
      r_bar_idx <= '0;
    end else if (w_bar_sum >= BAR_DIV) begin
      r_bar_acc <= 12'(w_bar_sum - BAR_DIV);
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_acc <= w_bar_sum[11:0];
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_row_addr <= '0;
      r_col_addr <= '0;
    end else if (w_fetch) begin
      r_col_addr <= r_h_cnt - H_START;
      r_row_addr <= r_v_cnt - V_START;
    end else begin
      r_col_addr <= '0;
      r_row_addr <= '0;
    end
  end

  assign w_ctl0 = '{
    hs:  (r_h_cnt < H_SYNC_END) ? HS_ON : HS_OFF,
    vs:  (r_v_cnt < V_SYNC_END) ? VS_ON : VS_OFF,
    de:  w_fetch,
    fs:  w_line_first && (r_v_cnt == V_START),
    ls:  w_line_first,
    bar: r_bar_idx
  };

  // NOTE: the delay line is reset like any other flop because its tail drives hs/vs/de straight to the pins.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k <= PIX_LAT; k++) r_dly[k] <= CTL_RST;
    end else begin
      r_dly[0] <= w_ctl0;
      for (int k = 1; k <= PIX_LAT; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign w_tail = r_dly[PIX_LAT];

  // Sampled only at the frame origin, which is deep in blanking, so a frame never tears.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_mode_q <= MODE_RGB;
    end else if ((r_h_cnt == 12'd0) && (r_v_cnt == 12'd0)) begin
      r_mode_q <= mode_e'(mode);
    end
  end

  // NOTE: w_rgb gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_rgb = 12'h000;
    if (w_tail.de) begin
      case (r_mode_q)
        MODE_RGB:  w_rgb = pixel_data;
        MODE_MONO: w_rgb = pixel_data[0] ? 12'h000 : 12'hFFF;
        MODE_BARS: w_rgb = bar_colour(w_tail.bar);
        default:   w_rgb = 12'h000;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_rgb <= '0;
      r_hs  <= HS_OFF;
      r_vs  <= VS_OFF;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= w_tail.hs;
      r_vs  <= w_tail.vs;
      r_de  <= w_tail.de;
      r_fs  <= w_tail.fs;
      r_ls  <= w_tail.ls;
    end
  end

  assign row_addr    = r_row_addr;
  assign col_addr    = r_col_addr;
  assign fetch_en    = r_dly[0].de;
  assign r           = r_rgb[11:8];
  assign g           = r_rgb[7:4];
  assign b           = r_rgb[3:0];
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;
  assign line_start  = r_ls;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: a position model queues expected pixels,
// a negedge monitor pops them whenever de is high and checks sync/de timing.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 20;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 5;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int HS_POL   = 1;
  localparam int VS_POL   = 0;
  localparam int PIX_LAT  = 3;

  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;   // 29
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;   // 10
  localparam int FRAME    = H_TOTAL * V_TOTAL;                  // 290
  localparam int H_START  = H_SYNC + H_BP;                      // 7
  localparam int V_START  = V_SYNC + V_BP;                      // 4
  localparam int LAT      = PIX_LAT + 2;                        // counter position -> pins
  localparam int FIRST_DE = LAT + V_START * H_TOTAL + H_START;  // 128

  localparam logic HS_ON  = 1'b1;
  localparam logic HS_OFF = 1'b0;
  localparam logic VS_ON  = 1'b0;
  localparam logic VS_OFF = 1'b1;

  typedef struct packed {
    logic [11:0] rgb;
    logic        fs;
    logic        ls;
  } exp_t;

  logic        vga_clk;
  logic        clrn;
  logic [1:0]  mode;
  logic [11:0] pixel_data;
  logic [11:0] row_addr;
  logic [11:0] col_addr;
  logic        fetch_en;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs;
  logic        vs;
  logic        de;
  logic        frame_start;
  logic        line_start;

  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LAT(PIX_LAT)
  ) u_dut (
    .vga_clk(vga_clk),
    .clrn(clrn),
    .mode(mode),
    .pixel_data(pixel_data),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .fetch_en(fetch_en),
    .r(r),
    .g(g),
    .b(b),
    .hs(hs),
    .vs(vs),
    .de(de),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Pixel source: low nibble is 0x5 on even columns, 0x4 on odd ones, so bit0 alternates.
  function automatic logic [11:0] src(input logic [11:0] row, input logic [11:0] col);
    return {col[3:0], row[3:0], 3'b010, ~col[0]};
  endfunction

  function automatic logic [11:0] bar_rgb(input int idx);
    logic [11:0] c;
    case (idx)
      0:       c = 12'hFFF;
      1:       c = 12'hFF0;
      2:       c = 12'h0FF;
      3:       c = 12'h0F0;
      4:       c = 12'hF0F;
      5:       c = 12'hF00;
      6:       c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [11:0] p1, p2, p3;
  initial begin
    p1 = '0;
    p2 = '0;
    p3 = '0;
  end
  always @(posedge vga_clk) begin
    p1 <= src(row_addr, col_addr);
    p2 <= p1;
    p3 <= p2;
  end
  assign pixel_data = p3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_de_rgb_strobes"}, 32'({de, r, g, b, frame_start, line_start, fetch_en}), 32'd0);
    check({tag, "_addr"}, 32'({row_addr, col_addr}), 32'd0);
    check({tag, "_hs"}, 32'(hs), 32'(HS_OFF));
    check({tag, "_vs"}, 32'(vs), 32'(VS_OFF));
  endtask

  // Reference raster: one position per clock, expected pixels queued in display order.
  int          m_h, m_v, m_col, m_row;
  logic [1:0]  m_mode;
  exp_t        m_e;
  logic [11:0] m_px;
  initial begin
    m_h = 0; m_v = 0; m_mode = 2'b00; cyc = 0;
    forever begin
      @(posedge vga_clk or negedge clrn);
      if (!clrn) begin
        m_h = 0; m_v = 0; m_mode = 2'b00; cyc = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (m_h == 0 && m_v == 0) m_mode = mode;
        if (m_h >= H_START && m_h < H_START + H_ACTIVE &&
            m_v >= V_START && m_v < V_START + V_ACTIVE) begin
          m_col = m_h - H_START;
          m_row = m_v - V_START;
          m_px  = src(12'(m_row), 12'(m_col));
          m_e.fs = (m_col == 0) && (m_row == 0);
          m_e.ls = (m_col == 0);
          case (m_mode)
            2'b00:   m_e.rgb = m_px;
            2'b01:   m_e.rgb = m_px[0] ? 12'h000 : 12'hFFF;
            2'b10:   m_e.rgb = bar_rgb((8 * m_col) / H_ACTIVE);
            default: m_e.rgb = 12'h000;
          endcase
          exp_q.push_back(m_e);
        end
        if (m_h == H_TOTAL - 1) begin
          m_h = 0;
          m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
    end
  end

  // Monitor: pops on every de cycle, measures sync/de edges in cycles since reset release.
  exp_t        got;
  logic        prev_hs_on, prev_vs_on, prev_de, prev_fe;
  logic        hs_seen, vs_seen, de_seen;
  int          hs_rise, vs_rise, de_rise, fe_rise, lines;
  logic [11:0] prev_col;
  initial begin
    prev_hs_on = 0; prev_vs_on = 0; prev_de = 0; prev_fe = 0;
    hs_seen = 0; vs_seen = 0; de_seen = 0;
    hs_rise = 0; vs_rise = 0; de_rise = 0; fe_rise = 0; lines = 0; prev_col = '0;
    forever begin
      @(negedge vga_clk);
      if (!clrn) begin
        prev_hs_on = 0; prev_vs_on = 0; prev_de = 0; prev_fe = 0;
        hs_seen = 0; vs_seen = 0; de_seen = 0; lines = 0;
      end else begin
        if (de) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL de_unexpected actual=de_high expected=no_pixel_pending cyc=%0d", cyc);
          end else begin
            got = exp_q.pop_front();
            check("pixel_rgb", 32'({r, g, b}), 32'(got.rgb));
            check("pixel_frame_start", 32'(frame_start), 32'(got.fs));
            check("pixel_line_start", 32'(line_start), 32'(got.ls));
          end
        end else begin
          check("blank_rgb_strobes", 32'({r, g, b, frame_start, line_start}), 32'd0);
        end

        if ((hs == HS_ON) && !prev_hs_on) begin
          if (!hs_seen) check("hs_first_edge", cyc, LAT);
          else          check("hs_period", cyc - hs_rise, H_TOTAL);
          hs_seen = 1;
          hs_rise = cyc;
        end
        if ((hs != HS_ON) && prev_hs_on) check("hs_width", cyc - hs_rise, H_SYNC);

        if ((vs == VS_ON) && !prev_vs_on) begin
          if (!vs_seen) check("vs_first_edge", cyc, LAT);
          else begin
            check("vs_period", cyc - vs_rise, FRAME);
            check("lines_per_frame", lines, V_ACTIVE);
          end
          vs_seen = 1;
          vs_rise = cyc;
          lines   = 0;
        end
        if ((vs != VS_ON) && prev_vs_on) check("vs_width", cyc - vs_rise, V_SYNC * H_TOTAL);

        if (fetch_en && !prev_fe) fe_rise = cyc;
        if (!fetch_en && prev_fe) check("last_col_addr", 32'(prev_col), H_ACTIVE - 1);
        if (!fetch_en) check("idle_addr", 32'({row_addr, col_addr}), 32'd0);

        if (de && !prev_de) begin
          if (!de_seen) check("first_pixel_cycle", cyc, FIRST_DE);
          de_seen = 1;
          check("de_after_hs", cyc - hs_rise, H_START);
          check("de_after_fetch", cyc - fe_rise, PIX_LAT + 1);
          de_rise = cyc;
          lines++;
        end
        if (!de && prev_de) check("de_width", cyc - de_rise, H_ACTIVE);

        prev_hs_on = (hs == HS_ON);
        prev_vs_on = (vs == VS_ON);
        prev_de    = de;
        prev_fe    = fetch_en;
        prev_col   = col_addr;
      end
    end
  end

  task automatic run_to(input int frame, input int line);
    int target;
    target = frame * FRAME + line * H_TOTAL + 16;
    while (cyc < target) begin
      @(posedge vga_clk);
      #2;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mode     = 2'b00;
    clrn     = 1'b1;
    #1 clrn  = 1'b0;
    repeat (3) @(posedge vga_clk);
    #2;
    check_reset("por");
    clrn = 1'b1;

    // Frame 0 RGB; mid-frame requests only take effect at the next frame.
    run_to(0, 6); mode = 2'b01;   // frame 1 mono
    run_to(1, 5); mode = 2'b10;   // frame 2 colour bars
    run_to(2, 7); mode = 2'b11;   // frame 3 blank
    run_to(3, 4); mode = 2'b00;   // frame 4 RGB

    // Reset while row 3 of frame 4 is on the pins.
    run_to(4, 7);
    check("pre_reset_de", 32'(de), 32'd1);
    clrn = 1'b0;
    #1;
    check_reset("mid");
    repeat (3) @(posedge vga_clk);
    #2;
    clrn = 1'b1;

    run_to(2, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal/vertical timing from configurable porch and sync widths, with selectable sync polarity.
- Issues registered pixel-fetch addresses to a frame/sprite source with configurable read latency and realigns sync and data-enable to the returned pixel.
- Adds an output mode select (direct RGB444, monochrome, colour bars, blank), frame/line strobes and a data-enable output.
- Sits between the game renderer's pixel source and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hs level during sync pulse (0 = active-low)
VS_POL, 0, vs level during sync pulse
PIX_LAT, 1, pixel_data latency in clocks after row_addr/col_addr (legal 0..4)

Ports:
vga_clk  in  1  pixel clock
clrn  in  1  asynchronous active-low reset
mode  in  2  00 RGB444, 01 mono, 10 colour bars, 11 blank
pixel_data  in  12  {r,g,b} returned by pixel source, PIX_LAT clocks after address
row_addr  out  12  visible row of current fetch
col_addr  out  12  visible column of current fetch
fetch_en  out  1  row_addr/col_addr valid (inside active area)
r  out  4  red
g  out  4  green
b  out  4  blue
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  data enable aligned with r/g/b
frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame on r/g/b
line_start  out  1  one-clock pulse aligned with the first active pixel of each active line on r/g/b

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- Defaults: H_TOTAL = 800, V_TOTAL = 525.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt = H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- Line layout: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. The frame is laid out the same way.
- Stage 0 (registered, 1 clock after counters):
  - fetch_en = h active AND v active.
  - When fetch_en = 1: col_addr = h_cnt-(H_SYNC+H_BP), row_addr = v_cnt-(V_SYNC+V_BP).
  - When fetch_en = 0: both addresses are 0.
- Raw sync = (h_cnt < H_SYNC); when active, hs = HS_POL, otherwise hs = ~HS_POL. vs is formed the same way from v_cnt.
- Delay line: hs, vs, fetch_en, frame/line flags and bar index are delayed PIX_LAT clocks, then registered once more together with the colour.
- Total latency: r/g/b/hs/vs/de appear PIX_LAT+1 clocks after the stage-0 address. Timing relative to sync is unchanged.
- Colour, evaluated in the final register:
  - de = 0 -> rgb = 0 (any mode).
  - mode 00 -> pixel_data.
  - mode 01 -> 0x000 if pixel_data[0] = 1, else 0xFFF.
  - mode 10 -> bar = col_addr*8/H_ACTIVE, using a per-line bar counter; no divider. Colours 0..7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - mode 11 -> 0.
- mode is sampled into mode_q only when h_cnt = 0 and v_cnt = 0. A change mid-frame takes effect at the next frame; there is no tearing.
- frame_start: de-aligned pulse on pixel (0,0). line_start: on col 0 of each active row. The two coincide on row 0.
- Reset (asynchronous, clrn = 0):
  - h_cnt = v_cnt = 0; delay line cleared; mode_q = 00.
  - Outputs: row_addr = col_addr = 0, fetch_en = de = 0, r = g = b = 0, hs = ~HS_POL, vs = ~VS_POL, frame_start = line_start = 0.
- Reset release mid-frame restarts at h = v = 0. The first frame is full length.
- PIX_LAT = 0: pixel_data is treated as combinational from the addresses and is sampled in the same clock.
- All address arithmetic is 12-bit unsigned, with no wrap visible outside the active area.

Test Plan:
- Defaults, reset then run 2 frames -> hs period 800 clocks, sync low for 96; vs period 420000 clocks, low for 1600; de high for 640 clocks per line on 480 lines per frame.
- PIX_LAT = 3, pixel source echoing {col_addr[3:0], row_addr[3:0], 4'h5} through a 3-stage pipe -> the first de pixel of row 2 is 0x025; hs/vs edges shift by exactly the same 3+1 clocks as de.
- Mode 10 at defaults -> cols 0..79 = FFF, col 80 = FF0, col 560..639 = 000; rgb = 0 whenever de = 0.
- Mode 01 with pixel_data alternating bit0 = 1/0 -> rgb alternates 000/FFF. Switching mode to 00 at line 100 has no effect until the next frame_start.
- Non-default H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, HS_POL=1 -> 1056-clock line, hs high for 128, col_addr reaches 799.
- Assert clrn low mid-line at row 200 -> immediate output reset values; after release, hs falls at clock 0 and frame_start occurs after one full blanking period.
